// File: rtl/bitwise_pkg.sv
// Shared opcode values and FSM state encoding for the bitwise processor.
package bitwise_pkg;

    localparam logic [3:0] OP_MOV  = 4'b0000;
    localparam logic [3:0] OP_MOVR = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b0111;
    localparam logic [3:0] OP_ASL  = 4'b1000;
    localparam logic [3:0] OP_LSR  = 4'b1001;
    localparam logic [3:0] OP_ASR  = 4'b1010;
    localparam logic [3:0] OP_ROL  = 4'b1011;
    localparam logic [3:0] OP_SWP  = 4'b1100;

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_LOAD = 3'd1,
        S_EXEC = 3'd2,
        S_WB2  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Register moves target R[rd]; every other legal op lands in R0.
    function automatic logic targets_rd(input logic [3:0] op);
        return (op == OP_MOV) || (op == OP_MOVR);
    endfunction

endpackage

// File: rtl/bitwise_alu.sv
// Purely combinational bitwise/shift unit; flags opcodes it does not know.
module bitwise_alu
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [WIDTH-1:0]         imm,
    input  logic [$clog2(WIDTH)-1:0] n,
    output logic [WIDTH-1:0]         result,
    output logic                     illegal
);

    logic [2*WIDTH-1:0] rot;

    // Decode the opcode into a result; rotate uses a doubled word so n=0 passes b through.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        result  = '0;
        illegal = 1'b0;
        rot     = {b, b} << n;
        case (op)
            OP_MOV:  result = imm;
            OP_MOVR: result = b;
            OP_XOR:  result = a ^ b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~b;
            OP_ASL:  result = b << n;
            OP_LSR:  result = b >> n;
            OP_ASR:  result = $signed(b) >>> n;
            OP_ROL:  result = rot[2*WIDTH-1:WIDTH];
            OP_SWP:  result = b;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/bitwise_dp.sv
// Datapath: register file, operand read ports, ALU and the registered R0 copy.
module bitwise_dp
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               op,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [$clog2(NREGS)-1:0] rs,
    input  logic [WIDTH-1:0]         imm,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     exec_we,
    input  logic                     wb2_we,
    output logic [WIDTH-1:0]         rdata_a,
    output logic [WIDTH-1:0]         rdata_b,
    output logic [WIDTH-1:0]         out,
    output logic                     illegal
);

    localparam int RW  = $clog2(NREGS);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] regs [0:NREGS-1];
    logic [WIDTH-1:0] result;
    logic [RW-1:0]    a_sel, b_sel, wdest;

    bitwise_alu #(.WIDTH(WIDTH)) alu (
        .op      (op),
        .a       (a),
        .b       (b),
        .imm     (imm),
        .n       (imm[SHW-1:0]),
        .result  (result),
        .illegal (illegal)
    );

    // Operand selection: SWP reads R0 and R[rd]; everything else reads R[rd] and R[rs].
    always_comb begin
        a_sel   = (op == OP_SWP) ? '0 : rd;
        b_sel   = (op == OP_SWP) ? rd : rs;
        wdest   = targets_rd(op) ? rd : '0;
        rdata_a = regs[a_sel];
        rdata_b = regs[b_sel];
    end

    // Register file writes (EXEC result, SWP second half) and the one-cycle-late R0 copy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register file is small and must read as zero after reset, so it is reset like plain flops.
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            out <= '0;
        end else begin
            if (exec_we && !illegal) regs[wdest] <= result;
            if (wb2_we)              regs[rd]    <= a;
            out <= regs[0];
        end
    end

endmodule

// File: rtl/bitwise_proc.sv
// Multi-cycle bitwise processor top: start/done handshake FSM, instruction and operand registers.
module bitwise_proc
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s,
    input  logic [3:0]               op,
    input  logic [$clog2(NREGS)-1:0] rd,
    input  logic [$clog2(NREGS)-1:0] rs,
    input  logic [WIDTH-1:0]         in,
    output logic [WIDTH-1:0]         out,
    output logic                     done,
    output logic                     busy,
    output logic                     err
);

    localparam int RW = $clog2(NREGS);

    state_t           state, next_state;
    logic [3:0]       op_q;
    logic [RW-1:0]    rd_q, rs_q;
    logic [WIDTH-1:0] imm_q, a_q, b_q;
    logic [WIDTH-1:0] rdata_a, rdata_b;
    logic             illegal;
    logic             load_en, exec_we, wb2_we;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) state <= S_WAIT;
        else       state <= next_state;
    end

    // Next-state logic: only S_WAIT looks at s; SWP takes an extra write-back state.
    always_comb begin
        next_state = state;
        case (state)
            S_WAIT:  if (s) next_state = S_LOAD;
            S_LOAD:  next_state = S_EXEC;
            S_EXEC:  next_state = (op_q == OP_SWP) ? S_WB2 : S_DONE;
            S_WB2:   next_state = S_DONE;
            S_DONE:  next_state = S_WAIT;
            default: next_state = S_WAIT;
        endcase
    end

    // Moore outputs and datapath strobes decoded from the current state.
    always_comb begin
        busy    = (state != S_WAIT);
        done    = (state == S_DONE);
        err     = done && illegal;
        load_en = (state == S_LOAD);
        exec_we = (state == S_EXEC);
        wb2_we  = (state == S_WB2);
    end

    // Instruction register: captured once at start, host inputs ignored until the next S_WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q  <= '0;
            rd_q  <= '0;
            rs_q  <= '0;
            imm_q <= '0;
        end else if (state == S_WAIT && s) begin
            op_q  <= op;
            rd_q  <= rd;
            rs_q  <= rs;
            imm_q <= in;
        end
    end

    // Operand registers loaded from the register file in S_LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q <= '0;
            b_q <= '0;
        end else if (load_en) begin
            a_q <= rdata_a;
            b_q <= rdata_b;
        end
    end

    bitwise_dp #(.WIDTH(WIDTH), .NREGS(NREGS)) DP (
        .clk     (clk),
        .reset   (reset),
        .op      (op_q),
        .rd      (rd_q),
        .rs      (rs_q),
        .imm     (imm_q),
        .a       (a_q),
        .b       (b_q),
        .exec_we (exec_we),
        .wb2_we  (wb2_we),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .out     (out),
        .illegal (illegal)
    );

endmodule

// File: tb/tb_bitwise_proc.sv
// Directed testbench for bitwise_proc at 8x4 and 16x8 configurations.
module tb_bitwise_proc;
    import bitwise_pkg::*;

    logic        clk = 1'b0;
    logic        reset;

    logic        s8;
    logic [3:0]  op8;
    logic [1:0]  rd8, rs8;
    logic [7:0]  in8, out8;
    logic        done8, busy8, err8;

    logic        s16;
    logic [3:0]  op16;
    logic [2:0]  rd16, rs16;
    logic [15:0] in16, out16;
    logic        done16, busy16, err16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bitwise_proc #(.WIDTH(8), .NREGS(4)) dut8 (
        .clk(clk), .reset(reset), .s(s8), .op(op8), .rd(rd8), .rs(rs8), .in(in8),
        .out(out8), .done(done8), .busy(busy8), .err(err8)
    );

    bitwise_proc #(.WIDTH(16), .NREGS(8)) dut16 (
        .clk(clk), .reset(reset), .s(s16), .op(op16), .rd(rd16), .rs(rs16), .in(in16),
        .out(out16), .done(done16), .busy(busy16), .err(err16)
    );

    // Issue one instruction to the 8-bit DUT; lat = negedges after the start edge until done (-1 on timeout).
    task automatic issue8(input logic [3:0] o, input logic [1:0] d, input logic [1:0] r,
                          input logic [7:0] v, output int lat, output logic e);
        @(negedge clk);
        op8 = o; rd8 = d; rs8 = r; in8 = v; s8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s8 = 1'b0; op8 = 4'b0010; in8 = ~v; rd8 = ~d; rs8 = ~r;
        lat = -1; e = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (done8) begin lat = c; e = err8; break; end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue16(input logic [3:0] o, input logic [2:0] d, input logic [2:0] r,
                           input logic [15:0] v, output int lat, output logic e);
        @(negedge clk);
        op16 = o; rd16 = d; rs16 = r; in16 = v; s16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s16 = 1'b0; op16 = 4'b0010; in16 = ~v; rd16 = ~d; rs16 = ~r;
        lat = -1; e = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (done16) begin lat = c; e = err16; break; end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        tests++; if (out8 !== 8'd0 || done8 !== 1'b0 || busy8 !== 1'b0 || err8 !== 1'b0) begin
            fails++; $display("FAIL reset_outputs: out=%0d done=%b busy=%b err=%b, need 0/0/0/0", out8, done8, busy8, err8);
        end
        for (int i = 0; i < 4; i++) begin
            tests++; if (dut8.DP.regs[i] !== 8'd0) begin
                fails++; $display("FAIL reset_reg%0d: got %0d need 0", i, dut8.DP.regs[i]);
            end
        end
        tests++; if (busy16 !== 1'b0 || out16 !== 16'd0) begin
            fails++; $display("FAIL reset_wide: busy=%b out=%0h need 0/0", busy16, out16);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mov();
        int lat; logic e;
        issue8(OP_MOV, 2'd1, 2'd0, 8'd42, lat, e);
        tests++; if (lat !== 3) begin fails++; $display("FAIL mov_latency: got %0d need 3", lat); end
        tests++; if (e !== 1'b0) begin fails++; $display("FAIL mov_err: got %b need 0", e); end
        tests++; if (dut8.DP.regs[1] !== 8'd42) begin fails++; $display("FAIL mov_r1: got %0d need 42", dut8.DP.regs[1]); end
        issue8(OP_MOV, 2'd2, 2'd0, 8'd11, lat, e);
        tests++; if (dut8.DP.regs[2] !== 8'd11) begin fails++; $display("FAIL mov_r2: got %0d need 11", dut8.DP.regs[2]); end
        issue8(OP_MOVR, 2'd3, 2'd1, 8'd0, lat, e);
        tests++; if (dut8.DP.regs[3] !== 8'd42 || lat !== 3) begin
            fails++; $display("FAIL movr_r3: got %0d lat %0d need 42 lat 3", dut8.DP.regs[3], lat);
        end
    endtask

    task automatic test_logic();
        int lat; logic e;
        issue8(OP_XOR, 2'd1, 2'd2, 8'd0, lat, e);
        tests++; if (dut8.DP.regs[0] !== 8'd33) begin fails++; $display("FAIL xor_r0: got %0d need 33", dut8.DP.regs[0]); end
        tests++; if (out8 !== 8'd33) begin fails++; $display("FAIL xor_out: got %0d need 33", out8); end
        issue8(OP_AND, 2'd1, 2'd2, 8'd0, lat, e);
        tests++; if (dut8.DP.regs[0] !== 8'd10) begin fails++; $display("FAIL and_r0: got %0d need 10", dut8.DP.regs[0]); end
        issue8(OP_OR, 2'd1, 2'd2, 8'd0, lat, e);
        tests++; if (dut8.DP.regs[0] !== 8'd43) begin fails++; $display("FAIL or_r0: got %0d need 43", dut8.DP.regs[0]); end
        issue8(OP_NOT, 2'd0, 2'd2, 8'd0, lat, e);
        tests++; if (dut8.DP.regs[0] !== 8'd244 || out8 !== 8'd244) begin
            fails++; $display("FAIL not_r0: got r0=%0d out=%0d need 244", dut8.DP.regs[0], out8);
        end
    endtask

    task automatic test_shifts();
        int lat; logic e;
        issue8(OP_ASL, 2'd0, 2'd1, 8'd1, lat, e);
        tests++; if (dut8.DP.regs[0] !== 8'd84) begin fails++; $display("FAIL asl_r0: got %0d need 84", dut8.DP.regs[0]); end
        issue8(OP_MOV, 2'd3, 2'd0, 8'h90, lat, e);
        issue8(OP_ASR, 2'd0, 2'd3, 8'd2, lat, e);
        tests++; if (dut8.DP.regs[0] !== 8'hE4) begin fails++; $display("FAIL asr_r0: got %0h need e4", dut8.DP.regs[0]); end
        issue8(OP_LSR, 2'd0, 2'd3, 8'd2, lat, e);
        tests++; if (dut8.DP.regs[0] !== 8'h24) begin fails++; $display("FAIL lsr_r0: got %0h need 24", dut8.DP.regs[0]); end
        issue8(OP_LSR, 2'd0, 2'd1, 8'd0, lat, e);
        tests++; if (dut8.DP.regs[0] !== 8'd42) begin fails++; $display("FAIL shift_n0: got %0d need 42", dut8.DP.regs[0]); end
        issue8(OP_MOV, 2'd3, 2'd0, 8'h81, lat, e);
        issue8(OP_ROL, 2'd0, 2'd3, 8'd1, lat, e);
        tests++; if (dut8.DP.regs[0] !== 8'h03) begin fails++; $display("FAIL rol_r0: got %0h need 03", dut8.DP.regs[0]); end
    endtask

    task automatic test_swap();
        int lat; logic e;
        issue8(OP_ASL, 2'd0, 2'd1, 8'd1, lat, e);
        issue8(OP_SWP, 2'd2, 2'd0, 8'd0, lat, e);
        tests++; if (lat !== 4) begin fails++; $display("FAIL swp_latency: got %0d need 4", lat); end
        tests++; if (dut8.DP.regs[0] !== 8'd11 || dut8.DP.regs[2] !== 8'd84) begin
            fails++; $display("FAIL swp_regs: got r0=%0d r2=%0d need 11/84", dut8.DP.regs[0], dut8.DP.regs[2]);
        end
        tests++; if (out8 !== 8'd11) begin fails++; $display("FAIL swp_out: got %0d need 11", out8); end
        issue8(OP_SWP, 2'd0, 2'd0, 8'd0, lat, e);
        tests++; if (dut8.DP.regs[0] !== 8'd11 || lat !== 4) begin
            fails++; $display("FAIL swp_r0_noop: got r0=%0d lat=%0d need 11 lat 4", dut8.DP.regs[0], lat);
        end
    endtask

    task automatic test_illegal();
        int lat; logic e;
        logic [7:0] expv [4];
        expv[0] = 8'd11; expv[1] = 8'd42; expv[2] = 8'd84; expv[3] = 8'h81;
        issue8(4'b0010, 2'd1, 2'd2, 8'd7, lat, e);
        tests++; if (lat !== 3 || e !== 1'b1) begin
            fails++; $display("FAIL illegal_done: got lat=%0d err=%b need 3/1", lat, e);
        end
        for (int i = 0; i < 4; i++) begin
            tests++; if (dut8.DP.regs[i] !== expv[i]) begin
                fails++; $display("FAIL illegal_reg%0d: got %0h need %0h", i, dut8.DP.regs[i], expv[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int ndone;
        @(negedge clk);
        op8 = OP_MOV; rd8 = 2'd3; in8 = 8'd7; s8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op8 = OP_MOV; rd8 = 2'd3; in8 = 8'd99;
        tests++; if (busy8 !== 1'b1) begin fails++; $display("FAIL busy_high: got %b need 1", busy8); end
        ndone = 0;
        for (int c = 0; c < 20 && !done8; c++) @(negedge clk);
        s8 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        tests++; if (ndone !== 0 || busy8 !== 1'b0) begin
            fails++; $display("FAIL busy_ignore: extra dones=%0d busy=%b need 0/0", ndone, busy8);
        end
        tests++; if (dut8.DP.regs[3] !== 8'd7) begin fails++; $display("FAIL busy_r3: got %0d need 7", dut8.DP.regs[3]); end
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        @(negedge clk);
        op8 = OP_MOV; rd8 = 2'd1; in8 = 8'd42; s8 = 1'b1;
        c1 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done8) begin c1 = c; break; end
        end
        in8 = 8'd50;
        c2 = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done8) begin c2 = c; break; end
        end
        s8 = 1'b0;
        tests++; if (c1 !== 3 || c2 !== 4) begin
            fails++; $display("FAIL back_to_back: got gaps %0d/%0d need 3/4", c1, c2);
        end
        @(negedge clk); @(negedge clk);
        tests++; if (dut8.DP.regs[1] !== 8'd50) begin fails++; $display("FAIL b2b_r1: got %0d need 50", dut8.DP.regs[1]); end
    endtask

    task automatic test_reset_mid();
        int lat, ndone; logic e;
        @(negedge clk);
        op8 = OP_XOR; rd8 = 2'd1; rs8 = 2'd2; s8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (dut8.DP.regs[i] !== 8'd0) begin
                fails++; $display("FAIL midreset_reg%0d: got %0d need 0", i, dut8.DP.regs[i]);
            end
        end
        tests++; if (out8 !== 8'd0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            fails++; $display("FAIL midreset_out: out=%0d busy=%b done=%b need 0/0/0", out8, busy8, done8);
        end
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        tests++; if (ndone !== 0) begin fails++; $display("FAIL midreset_nodone: got %0d dones need 0", ndone); end
        issue8(OP_MOV, 2'd1, 2'd0, 8'd5, lat, e);
        tests++; if (lat !== 3 || dut8.DP.regs[1] !== 8'd5) begin
            fails++; $display("FAIL midreset_mov: got lat=%0d r1=%0d need 3/5", lat, dut8.DP.regs[1]);
        end
    endtask

    task automatic test_wide();
        int lat; logic e;
        issue16(OP_MOV, 3'd7, 3'd0, 16'hABCD, lat, e);
        tests++; if (lat !== 3 || dut16.DP.regs[7] !== 16'hABCD) begin
            fails++; $display("FAIL wide_mov: got lat=%0d r7=%0h need 3/abcd", lat, dut16.DP.regs[7]);
        end
        issue16(OP_MOV, 3'd1, 3'd0, 16'h1234, lat, e);
        issue16(OP_XOR, 3'd7, 3'd1, 16'h0000, lat, e);
        tests++; if (dut16.DP.regs[0] !== 16'hB9F9 || out16 !== 16'hB9F9) begin
            fails++; $display("FAIL wide_xor: got r0=%0h out=%0h need b9f9", dut16.DP.regs[0], out16);
        end
        issue16(OP_SWP, 3'd7, 3'd0, 16'h0000, lat, e);
        tests++; if (lat !== 4 || dut16.DP.regs[0] !== 16'hABCD || dut16.DP.regs[7] !== 16'hB9F9) begin
            fails++; $display("FAIL wide_swp: got lat=%0d r0=%0h r7=%0h need 4/abcd/b9f9", lat, dut16.DP.regs[0], dut16.DP.regs[7]);
        end
        issue16(OP_ROL, 3'd0, 3'd1, 16'd4, lat, e);
        tests++; if (dut16.DP.regs[0] !== 16'h2341 || e !== 1'b0) begin
            fails++; $display("FAIL wide_rol: got r0=%0h err=%b need 2341/0", dut16.DP.regs[0], e);
        end
    endtask

    initial begin
        s8 = 1'b0; op8 = '0; rd8 = '0; rs8 = '0; in8 = '0;
        s16 = 1'b0; op16 = '0; rd16 = '0; rs16 = '0; in16 = '0;
        test_reset();
        test_mov();
        test_logic();
        test_shifts();
        test_swap();
        test_illegal();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
